// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath strobes per state.
// Latency: 3-5 cycles per instruction with zero wait; each memory wait cycle in FETCH/MEM adds one.
// Backpressure: stalls in FETCH/MEM until mem_ready_i; optional MCU_TRAP_EN adds illegal-opcode and timeout traps.
module multicycle_control_unit #(
    parameter int OPC_W    = 5,
    parameter int WAIT_W   = 4,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [OPC_W-1:0]  opcode_i,
    input  logic              mem_ready_i,
    output logic              ir_write_o,
    output logic              pc_write_o,
    output logic              branch_o,
    output logic              jump_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [1:0]        mem_to_reg_o,
    output logic              alu_src_o,
    output logic [1:0]        alu_op_o,
    output logic              reg_write_o,
    output logic              halted_o,
    output logic              trap_o,
    output logic [1:0]        trap_cause_o
);

    localparam logic [OPC_W-1:0] OP_R      = OPC_W'(5'b01100);
    localparam logic [OPC_W-1:0] OP_I      = OPC_W'(5'b00100);
    localparam logic [OPC_W-1:0] OP_LOAD   = OPC_W'(5'b00000);
    localparam logic [OPC_W-1:0] OP_STORE  = OPC_W'(5'b01000);
    localparam logic [OPC_W-1:0] OP_BRANCH = OPC_W'(5'b11000);
    localparam logic [OPC_W-1:0] OP_JAL    = OPC_W'(5'b11011);
    localparam logic [OPC_W-1:0] OP_JALR   = OPC_W'(5'b11001);
    localparam logic [OPC_W-1:0] OP_LUI    = OPC_W'(5'b01101);
    localparam logic [OPC_W-1:0] OP_AUIPC  = OPC_W'(5'b00101);
    localparam logic [OPC_W-1:0] OP_SYSTEM = OPC_W'(5'b11100);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_TRAP
    } state_t;

    state_t              state_q, state_d;
    logic [OPC_W-1:0]    op_q, op_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [1:0]          trap_cause_q, trap_cause_d;

    logic                is_load;
    logic                is_store;
    logic                is_jump;
    logic                timeout;
    logic [WAIT_W-1:0]   wait_inc;

    assign is_load  = (op_q == OP_LOAD);
    assign is_store = (op_q == OP_STORE);
    assign is_jump  = (op_q == OP_JAL) || (op_q == OP_JALR);

    // Counter holds at its limit instead of wrapping
    assign wait_inc = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + 1'b1;

`ifdef MCU_TRAP_EN
    assign timeout = (wait_cnt_q == WAIT_MAX);
`else
    assign timeout = 1'b0;
`endif

    // Next-state, opcode latch, wait counter and trap cause
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        wait_cnt_d   = '0;
        trap_cause_d = trap_cause_q;
        case (state_q)
            S_FETCH, S_MEM: begin
                if (mem_ready_i) begin
                    if (state_q == S_FETCH) begin
                        state_d = S_DECODE;
                    end else begin
                        state_d = is_load ? S_WB : S_FETCH;
                    end
                end else if (timeout) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'b10;
                end else begin
                    wait_cnt_d = wait_inc;
                end
            end
            S_DECODE: begin
                op_d    = opcode_i;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_R, OP_I, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: state_d = S_WB;
                    OP_LOAD, OP_STORE:                             state_d = S_MEM;
                    OP_BRANCH:                                     state_d = S_FETCH;
                    OP_SYSTEM:                                     state_d = S_HALT;
                    default: begin
`ifdef MCU_TRAP_EN
                        state_d      = S_TRAP;
                        trap_cause_d = 2'b01;
`else
                        state_d      = S_FETCH;
`endif
                    end
                endcase
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = state_q;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_FETCH;
            op_q         <= '0;
            wait_cnt_q   <= '0;
            trap_cause_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            wait_cnt_q   <= wait_cnt_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    // Datapath strobes decoded from state, latched opcode and mem_ready; all forced low in reset
    always_comb begin
        ir_write_o   = 1'b0;
        pc_write_o   = 1'b0;
        branch_o     = 1'b0;
        jump_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_to_reg_o = 2'b00;
        alu_src_o    = 1'b0;
        alu_op_o     = 2'b00;
        reg_write_o  = 1'b0;
        halted_o     = 1'b0;
        trap_o       = 1'b0;
        trap_cause_o = 2'b00;
        if (!rst_i) begin
            trap_cause_o = trap_cause_q;
            case (state_q)
                S_FETCH: begin
                    mem_read_o = 1'b1;
                    ir_write_o = mem_ready_i;
                end
                S_EXEC: begin
                    case (op_q)
                        OP_R: alu_op_o = 2'b10;
                        OP_I: begin
                            alu_op_o  = 2'b11;
                            alu_src_o = 1'b1;
                        end
                        OP_LUI, OP_AUIPC, OP_LOAD, OP_STORE: alu_src_o = 1'b1;
                        OP_BRANCH: begin
                            alu_op_o   = 2'b01;
                            branch_o   = 1'b1;
                            pc_write_o = 1'b1;
                        end
                        OP_JAL:  jump_o = 1'b1;
                        OP_JALR: begin
                            jump_o    = 1'b1;
                            alu_src_o = 1'b1;
                        end
                        OP_SYSTEM: ;
`ifdef MCU_TRAP_EN
                        default: ;
`else
                        default: pc_write_o = 1'b1;
`endif
                    endcase
                end
                S_MEM: begin
                    mem_read_o  = is_load;
                    mem_write_o = is_store;
                    pc_write_o  = is_store && mem_ready_i;
                end
                S_WB: begin
                    reg_write_o  = 1'b1;
                    pc_write_o   = 1'b1;
                    jump_o       = is_jump;
                    mem_to_reg_o = is_load ? 2'b01 : (is_jump ? 2'b10 : 2'b00);
                end
                S_HALT:  halted_o = 1'b1;
                S_TRAP:  trap_o   = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected output sequences built from instruction classes.
module tb_multicycle_control_unit;

`ifdef MCU_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif
    localparam int MAX_WAIT = 15;

    // Output vector bit assignments
    localparam logic [15:0] B_IR   = 16'h8000;
    localparam logic [15:0] B_PC   = 16'h4000;
    localparam logic [15:0] B_BR   = 16'h2000;
    localparam logic [15:0] B_JP   = 16'h1000;
    localparam logic [15:0] B_MR   = 16'h0800;
    localparam logic [15:0] B_MW   = 16'h0400;
    localparam logic [15:0] M2R_MEM = 16'h0100;
    localparam logic [15:0] M2R_PC4 = 16'h0200;
    localparam logic [15:0] B_AS   = 16'h0080;
    localparam logic [15:0] AOP_BR = 16'h0020;
    localparam logic [15:0] AOP_R  = 16'h0040;
    localparam logic [15:0] AOP_I  = 16'h0060;
    localparam logic [15:0] B_RW   = 16'h0010;
    localparam logic [15:0] B_H    = 16'h0008;
    localparam logic [15:0] B_T    = 16'h0004;
    localparam logic [15:0] TC_ILL = 16'h0001;
    localparam logic [15:0] TC_TO  = 16'h0002;

    localparam logic [4:0] OP_R = 5'b01100, OP_I = 5'b00100, OP_LD = 5'b00000, OP_ST = 5'b01000;
    localparam logic [4:0] OP_BR = 5'b11000, OP_JAL = 5'b11011, OP_JALR = 5'b11001;
    localparam logic [4:0] OP_LUI = 5'b01101, OP_AUIPC = 5'b00101, OP_SYS = 5'b11100, OP_ILL = 5'b11111;

    localparam int C_R = 0, C_I = 1, C_UI = 2, C_LD = 3, C_ST = 4, C_BR = 5;
    localparam int C_JAL = 6, C_JALR = 7, C_SYS = 8, C_ILL = 9;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [4:0] opcode_i;
    logic       mem_ready_i;
    logic       ir_write_o, pc_write_o, branch_o, jump_o, mem_read_o, mem_write_o;
    logic [1:0] mem_to_reg_o, alu_op_o, trap_cause_o;
    logic       alu_src_o, reg_write_o, halted_o, trap_o;

    logic [15:0] dut_vec;
    logic [15:0] exp_v;
    logic        chk_en = 1'b0;
    string       tag = "";
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    multicycle_control_unit #(.OPC_W(5), .WAIT_W(4), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .opcode_i     (opcode_i),
        .mem_ready_i  (mem_ready_i),
        .ir_write_o   (ir_write_o),
        .pc_write_o   (pc_write_o),
        .branch_o     (branch_o),
        .jump_o       (jump_o),
        .mem_read_o   (mem_read_o),
        .mem_write_o  (mem_write_o),
        .mem_to_reg_o (mem_to_reg_o),
        .alu_src_o    (alu_src_o),
        .alu_op_o     (alu_op_o),
        .reg_write_o  (reg_write_o),
        .halted_o     (halted_o),
        .trap_o       (trap_o),
        .trap_cause_o (trap_cause_o)
    );

    always #5 clk = ~clk;

    assign dut_vec = {ir_write_o, pc_write_o, branch_o, jump_o, mem_read_o, mem_write_o,
                      mem_to_reg_o, alu_src_o, alu_op_o, reg_write_o, halted_o, trap_o, trap_cause_o};

    // Compare process: every driven cycle, DUT outputs against the model's expectation
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (dut_vec !== exp_v) begin
                errors++;
                $display("FAIL %s cycle %0d outputs got %h expected %h", tag, cyc, dut_vec, exp_v);
            end
        end
    end

    function automatic int cls(input logic [4:0] op);
        case (op)
            OP_R:             return C_R;
            OP_I:             return C_I;
            OP_LUI, OP_AUIPC: return C_UI;
            OP_LD:            return C_LD;
            OP_ST:            return C_ST;
            OP_BR:            return C_BR;
            OP_JAL:           return C_JAL;
            OP_JALR:          return C_JALR;
            OP_SYS:           return C_SYS;
            default:          return C_ILL;
        endcase
    endfunction

    function automatic logic [15:0] exec_vec(input logic [4:0] op);
        case (cls(op))
            C_R:         return AOP_R;
            C_I:         return AOP_I | B_AS;
            C_UI:        return B_AS;
            C_LD, C_ST:  return B_AS;
            C_BR:        return AOP_BR | B_BR | B_PC;
            C_JAL:       return B_JP;
            C_JALR:      return B_JP | B_AS;
            C_SYS:       return 16'h0000;
            default:     return TRAP_EN ? 16'h0000 : B_PC;
        endcase
    endfunction

    function automatic logic [15:0] wb_vec(input logic [4:0] op);
        case (cls(op))
            C_LD:          return B_RW | B_PC | M2R_MEM;
            C_JAL, C_JALR: return B_RW | B_PC | M2R_PC4 | B_JP;
            default:       return B_RW | B_PC;
        endcase
    endfunction

    function automatic logic rnd();
        return 1'($urandom_range(0, 1));
    endfunction

    // One clock cycle: drive inputs just after the edge and post the expected outputs
    task automatic step(input logic rdy, input logic rs, input logic [15:0] e, input string name);
        @(posedge clk);
        #1;
        mem_ready_i = rdy;
        rst_i       = rs;
        exp_v       = e;
        tag         = name;
        chk_en      = 1'b1;
        cyc++;
    endtask

    task automatic lit(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic rst_cycles(input int n);
        for (int i = 0; i < n; i++) step(rnd(), 1'b1, 16'h0000, "reset");
    endtask

    // Memory access phase: nw not-ready cycles then a ready cycle, unless the wait limit trips first
    task automatic acc_phase(input int nw, input logic [15:0] v_wait, input logic [15:0] v_done,
                             input string name, output bit timed_out);
        timed_out = 1'b0;
        for (int i = 0; i < nw; i++) begin
            step(1'b0, 1'b0, v_wait, name);
            if (TRAP_EN && i == MAX_WAIT) begin
                timed_out = 1'b1;
                return;
            end
        end
        step(1'b1, 1'b0, v_done, name);
    endtask

    task automatic trap_phase(input logic [15:0] cause);
        for (int i = 0; i < 3; i++) step(rnd(), 1'b0, B_T | cause, "trap");
    endtask

    task automatic run_instr(input logic [4:0] op, input int fw, input int mw, output int ncyc);
        int c0;
        bit to;
        c0 = cyc;
        opcode_i = op;
        acc_phase(fw, B_MR, B_MR | B_IR, "fetch", to);
        if (to) begin
            trap_phase(TC_TO);
            ncyc = cyc - c0;
            return;
        end
        step(rnd(), 1'b0, 16'h0000, "decode");
        step(rnd(), 1'b0, exec_vec(op), "exec");
        case (cls(op))
            C_R, C_I, C_UI, C_JAL, C_JALR: step(rnd(), 1'b0, wb_vec(op), "wb");
            C_LD: begin
                acc_phase(mw, B_MR, B_MR, "mem_ld", to);
                if (to) trap_phase(TC_TO);
                else    step(rnd(), 1'b0, wb_vec(op), "wb");
            end
            C_ST: begin
                acc_phase(mw, B_MW, B_MW | B_PC, "mem_st", to);
                if (to) trap_phase(TC_TO);
            end
            C_ILL: if (TRAP_EN) trap_phase(TC_ILL);
            default: ;
        endcase
        ncyc = cyc - c0;
    endtask

    initial begin
        int n;
        rst_i       = 1'b1;
        mem_ready_i = 1'b0;
        opcode_i    = 5'b00000;

        rst_cycles(2);

        run_instr(OP_R, 0, 0, n);      lit("len_R", n, 4);
        run_instr(OP_I, 0, 0, n);      lit("len_I", n, 4);
        run_instr(OP_LUI, 1, 0, n);    lit("len_LUI_w1", n, 5);
        run_instr(OP_AUIPC, 0, 0, n);
        run_instr(OP_JAL, 0, 0, n);    lit("len_JAL", n, 4);
        run_instr(OP_JALR, 2, 0, n);
        run_instr(OP_LD, 0, 3, n);     lit("len_LD_w3", n, 8);
        run_instr(OP_LD, 0, 0, n);     lit("len_LD", n, 5);
        run_instr(OP_ST, 0, 0, n);     lit("len_ST", n, 4);
        run_instr(OP_ST, 2, 1, n);     lit("len_ST_w3", n, 7);
        run_instr(OP_BR, 0, 0, n);     lit("len_BR", n, 3);
        run_instr(OP_LD, 15, 15, n);   lit("len_LD_w30", n, 35);

`ifdef MCU_TRAP_EN
        run_instr(OP_ILL, 0, 0, n);
        #2 lit("trap_ill_cause", trap_cause_o, 1);
        rst_cycles(1);
        run_instr(OP_R, 16, 0, n);
        #2 lit("trap_to_cause", trap_cause_o, 2);
        rst_cycles(1);
        run_instr(OP_LD, 0, 16, n);
        rst_cycles(1);
`else
        run_instr(OP_ILL, 0, 0, n);    lit("len_ILL_nop", n, 3);
        run_instr(OP_R, 20, 0, n);
`endif

        run_instr(OP_SYS, 0, 0, n);    lit("len_SYS", n, 3);
        for (int i = 0; i < 4; i++) step(rnd(), 1'b0, B_H, "halt");
        #2 lit("halted_sticky", halted_o, 1);
        rst_cycles(1);
        #2 lit("rst_memread", mem_read_o, 0);
        step(1'b0, 1'b0, B_MR, "fetch_wait");
        step(1'b0, 1'b0, B_MR, "fetch_wait");
        rst_cycles(1);
        step(1'b0, 1'b0, B_MR, "post_rst");
        #2 lit("post_rst_memread", mem_read_o, 1);
        run_instr(OP_R, 0, 0, n);

        @(negedge clk);
        #1 chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
